// File: rtl/z80_im2_intctrl.sv
// z80_im2_intctrl: Z80 IM2 interrupt controller with edge capture, mask, fixed priority nesting and RETI snooping
module z80_im2_intctrl #(
  parameter int          NUM_CH   = 8,
  parameter logic [7:0]  VEC_BASE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic              mask_wr,
  input  logic [NUM_CH-1:0] mask_wdata,
  input  logic [NUM_CH-1:0] pend_clr,
  output logic [NUM_CH-1:0] mask,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] in_service,
  input  logic              cpu_m1_n,
  input  logic              cpu_iorq_n,
  input  logic              m1_fetch,
  input  logic [7:0]        fetch_data,
  output logic              int_n,
  output logic              vec_oe,
  output logic [7:0]        vec_data
);
  typedef enum logic {IDLE, SAW_ED} reti_e;
  reti_e st_q, st_d;
  logic [NUM_CH-1:0] irq_q, mask_q, pend_q, isv_q, mask_d, pend_d, isv_d, elig, ack_bit;
  logic intack, intack_q, ack_rise, ack_ok, vec_oe_q, vec_oe_d, int_n_q, win_v, fire, fetch, reti;
  logic [4:0] win, isx;
  logic [7:0] vec_q, vec_d;
  assign intack   = ~cpu_m1_n & ~cpu_iorq_n;
  assign ack_rise = intack & ~intack_q;
  assign elig     = pend_q & mask_q;
  assign fetch    = m1_fetch & ~intack;
  // Scan downwards so the lowest index wins for both the request and the active service level
  always_comb begin
    win   = 5'd0;
    win_v = 1'b0;
    isx   = 5'(NUM_CH);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win   = 5'(i);
        win_v = 1'b1;
      end
      if (isv_q[i]) isx = 5'(i);
    end
  end
  always_comb begin
    fire     = win_v & (win < isx);
    ack_ok   = ack_rise & ~int_n_q & win_v;
    ack_bit  = ack_ok ? (NUM_CH'(1) << win) : '0;
    reti     = fetch & (st_q == SAW_ED) & (fetch_data == 8'h4D);
    st_d     = fetch ? ((fetch_data == 8'hED) ? SAW_ED : IDLE) : st_q;
    mask_d   = mask_wr ? mask_wdata : mask_q;
    pend_d   = (pend_q & ~pend_clr & ~ack_bit) | (irq_in & ~irq_q);
    isv_d    = (reti ? (isv_q & (isv_q - NUM_CH'(1))) : isv_q) | ack_bit;
    vec_d    = ack_rise ? (ack_ok ? VEC_BASE + 8'({win, 1'b0}) : VEC_BASE + 8'(2 * NUM_CH)) : vec_q;
    vec_oe_d = intack & (ack_rise | vec_oe_q);
  end
  // History registers load live inputs in reset so held levels do not fire afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q    <= irq_in;
      intack_q <= intack;
      mask_q   <= '0;
      pend_q   <= '0;
      isv_q    <= '0;
      int_n_q  <= 1'b1;
      vec_oe_q <= 1'b0;
      vec_q    <= VEC_BASE;
      st_q     <= IDLE;
    end else begin
      irq_q    <= irq_in;
      intack_q <= intack;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      isv_q    <= isv_d;
      int_n_q  <= ~fire;
      vec_oe_q <= vec_oe_d;
      vec_q    <= vec_d;
      st_q     <= st_d;
    end
  end
  assign mask       = mask_q;
  assign pending    = pend_q;
  assign in_service = isv_q;
  assign int_n      = int_n_q;
  assign vec_oe     = vec_oe_q;
  assign vec_data   = vec_q;
endmodule
